program_loader: RTL

Upstream feeder for the CPU's unified load port. Accepts a framed byte stream over a valid/ready handshake, writes the instruction and data images through the CPU's `cpu_input`/`load_address`/`load`/`is_instruction` inputs, and holds the CPU in reset until the frame's checksum verifies. The block sits between a byte source (UART receiver, testbench, boot ROM streamer) and the CPU top.

---
 rtl/loader_pkg.sv | 31 +++
 rtl/program_loader.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: shared definitions for the program loader.
//   - state_t      : loader FSM states
//   - SOF_DEFAULT  : default start-of-frame byte
//   - MAX_*_DEFAULT: default instruction/data memory depths
//   - INSTR_AW / DATA_AW : instruction/data address widths
//   - ck_fold      : running XOR checksum step
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ICOUNT = 3'd1,
    ST_IDATA  = 3'd2,
    ST_DCOUNT = 3'd3,
    ST_DDATA  = 3'd4,
    ST_CHECK  = 3'd5,
    ST_RUN    = 3'd6,
    ST_ERROR  = 3'd7
  } state_t;

  localparam logic [7:0] SOF_DEFAULT       = 8'hA5;
  localparam int         MAX_INSTR_DEFAULT = 32;
  localparam int         MAX_DATA_DEFAULT  = 16;
  localparam int         INSTR_AW          = 5;
  localparam int         DATA_AW           = 4;

  // One step of the frame checksum: XOR the accepted byte into the accumulator.
  function automatic logic [7:0] ck_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/program_loader.sv
// program_loader: receives a framed byte stream (SOF, NI, instr bytes, ND,
// data bytes, CK) and writes it into the CPU through its load port, keeping
// the CPU in reset until a frame's checksum verifies.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   rx_data/valid/ready  : byte input handshake (transfer on valid && ready)
//   cpu_input            : byte written to the CPU
//   load_address         : CPU memory address (data uses {1'b0, idx[3:0]})
//   load                 : one-cycle write strobe
//   is_instruction       : 1 = instruction memory, 0 = data memory
//   cpu_reset            : CPU reset, low only in RUN
//   done / error         : status levels for RUN / ERROR
module program_loader
  import loader_pkg::*;
#(
  parameter logic [7:0] SOF       = SOF_DEFAULT,
  parameter int         MAX_INSTR = MAX_INSTR_DEFAULT,
  parameter int         MAX_DATA  = MAX_DATA_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic [7:0]          cpu_input,
  output logic [INSTR_AW-1:0] load_address,
  output logic                load,
  output logic                is_instruction,
  output logic                cpu_reset,
  output logic                done,
  output logic                error
);

  localparam logic [7:0] MAX_INSTR_B = 8'(MAX_INSTR);
  localparam logic [7:0] MAX_DATA_B  = 8'(MAX_DATA);

  state_t              state_r, state_s;
  logic [INSTR_AW-1:0] idx_r, idx_s;
  logic [INSTR_AW-1:0] last_r, last_s;   // terminal index (count - 1)
  logic [7:0]          ck_r, ck_s;
  logic                load_r, load_s;
  logic [7:0]          din_r, din_s;
  logic [INSTR_AW-1:0] addr_r, addr_s;
  logic                instr_r, instr_s;
  logic                cpu_reset_r, done_r, error_r;
  logic                accept_s;

  // Ready drops for the cycle after every write, which paces payload bytes.
  assign rx_ready = !reset && !load_r;
  assign accept_s = rx_valid && rx_ready;

  assign cpu_input      = din_r;
  assign load_address   = addr_r;
  assign load           = load_r;
  assign is_instruction = instr_r;
  assign cpu_reset      = cpu_reset_r;
  assign done           = done_r;
  assign error          = error_r;

  // Next-state, counter, checksum and load-port values for the accepted byte.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    last_s  = last_r;
    ck_s    = ck_r;
    load_s  = 1'b0;
    din_s   = din_r;
    addr_s  = addr_r;
    instr_s = instr_r;
    if (accept_s) begin
      case (state_r)
        ST_IDLE, ST_RUN, ST_ERROR: begin
          if (rx_data == SOF) begin
            state_s = ST_ICOUNT;
            ck_s    = 8'h00;
          end else begin
            state_s = state_r;
          end
        end
        ST_ICOUNT: begin
          ck_s = ck_fold(ck_r, rx_data);
          if ((rx_data == 8'h00) || (rx_data > MAX_INSTR_B)) begin
            state_s = ST_ERROR;
          end else begin
            state_s = ST_IDATA;
            idx_s   = '0;
            // 32 truncates to 0; minus one gives 31, the correct last index.
            last_s  = rx_data[INSTR_AW-1:0] - 5'd1;
          end
        end
        ST_IDATA: begin
          ck_s    = ck_fold(ck_r, rx_data);
          load_s  = 1'b1;
          din_s   = rx_data;
          addr_s  = idx_r;
          instr_s = 1'b1;
          if (idx_r == last_r) begin
            state_s = ST_DCOUNT;
          end else begin
            idx_s = idx_r + 5'd1;
          end
        end
        ST_DCOUNT: begin
          ck_s = ck_fold(ck_r, rx_data);
          if (rx_data > MAX_DATA_B) begin
            state_s = ST_ERROR;
          end else if (rx_data == 8'h00) begin
            state_s = ST_CHECK;
          end else begin
            state_s = ST_DDATA;
            idx_s   = '0;
            last_s  = rx_data[INSTR_AW-1:0] - 5'd1;
          end
        end
        ST_DDATA: begin
          ck_s    = ck_fold(ck_r, rx_data);
          load_s  = 1'b1;
          din_s   = rx_data;
          addr_s  = {1'b0, idx_r[DATA_AW-1:0]};
          instr_s = 1'b0;
          if (idx_r == last_r) begin
            state_s = ST_CHECK;
          end else begin
            idx_s = idx_r + 5'd1;
          end
        end
        ST_CHECK: begin
          // CK itself is compared, never folded into the accumulator.
          if (rx_data == ck_r) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_ERROR;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State, counters and the registered CPU load port / status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      idx_r       <= '0;
      last_r      <= '0;
      ck_r        <= 8'h00;
      load_r      <= 1'b0;
      din_r       <= 8'h00;
      addr_r      <= '0;
      instr_r     <= 1'b0;
      cpu_reset_r <= 1'b1;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      last_r      <= last_s;
      ck_r        <= ck_s;
      load_r      <= load_s;
      din_r       <= din_s;
      addr_r      <= addr_s;
      instr_r     <= instr_s;
      // Status follows the next state so CPU release lands on the CK edge.
      cpu_reset_r <= (state_s != ST_RUN);
      done_r      <= (state_s == ST_RUN);
      error_r     <= (state_s == ST_ERROR);
    end
  end

endmodule
